// File: rtl/ram2x8_ctrl_if.sv
// Host command/response channels plus the ram2x8 memory port, bundled so the
// controller and its environment share one set of signal definitions.
// The master side is the host together with the RAM; the slave side is the
// controller itself.
interface ram2x8_ctrl_if #(
    parameter int DATA_W = 8
);
    // host command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    // host response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // ram2x8 memory port
    logic              mem_rw;
    logic              mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_clear;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_rw, mem_addr, mem_wdata, mem_clear
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output mem_rw, mem_addr, mem_wdata, mem_clear
    );
endinterface

// File: rtl/ram2x8_ctrl.sv
// Initiator-side controller for a 2-word ram2x8 memory. Accepts read, write,
// verify (write then read-back compare) and clear-all commands from a host
// and owns all timing of mem_rw / mem_addr / mem_clear. Every output is a
// register loaded from the next-state decode, so each output lines up with
// the state the FSM is entering.
module ram2x8_ctrl #(
    parameter int DATA_W    = 8,
    parameter int READ_WAIT = 1
) (
    input  logic            clk,
    input  logic            clear,
    ram2x8_ctrl_if.slave    bus
);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_VERIFY = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    // the counter counts down to zero, so the load value is one less than the
    // number of WAIT cycles
    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLR   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // latched command
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_data;
    logic [3:0]          r_wait_cnt;

    // registered outputs
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic                r_mem_rw;
    logic                r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_clear;

    // next values for the registers above
    logic [1:0]          w_op_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [3:0]          w_wait_cnt_nxt;
    logic                w_cmd_ready_nxt;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   w_rsp_data_nxt;
    logic                w_rsp_err_nxt;
    logic                w_mem_rw_nxt;
    logic                w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_mem_clear_nxt;

    logic                w_accept;
    logic                w_wait_last;
    logic                w_sample;

    // cmd_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_accept    = bus.cmd_valid & r_cmd_ready;
    assign w_wait_last = (r_wait_cnt == 4'd0);
    assign w_sample    = (r_state == ST_WAIT) & w_wait_last;

    // state register; an asynchronous clear aborts any command in flight
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_READ:   w_state_nxt = ST_WAIT;
                        OP_WRITE:  w_state_nxt = ST_WRITE;
                        OP_VERIFY: w_state_nxt = ST_WRITE;
                        OP_CLEAR:  w_state_nxt = ST_CLR;
                        default:   w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (r_op == OP_VERIFY) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (w_wait_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_CLR: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // output and datapath decode from the state being entered
    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
        w_mem_rw_nxt    = (w_state_nxt == ST_WRITE);
        w_mem_clear_nxt = (w_state_nxt == ST_CLR);

        // command fields and address are captured only at acceptance
        if (w_accept) begin
            w_op_nxt       = bus.cmd_op;
            w_data_nxt     = bus.cmd_data;
            w_mem_addr_nxt = bus.cmd_addr;
        end else begin
            w_op_nxt       = r_op;
            w_data_nxt     = r_data;
            w_mem_addr_nxt = r_mem_addr;
        end

        // write data only changes when a write is actually about to happen
        if (w_accept && ((bus.cmd_op == OP_WRITE) || (bus.cmd_op == OP_VERIFY))) begin
            w_mem_wdata_nxt = bus.cmd_data;
        end else begin
            w_mem_wdata_nxt = r_mem_wdata;
        end

        // load on WAIT entry, count down while waiting
        if ((w_state_nxt == ST_WAIT) && (r_state != ST_WAIT)) begin
            w_wait_cnt_nxt = WAIT_LOAD;
        end else if ((r_state == ST_WAIT) && !w_wait_last) begin
            w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end else begin
            w_wait_cnt_nxt = 4'd0;
        end

        // write/clear respond with zero data, so clear it at acceptance
        if (w_accept) begin
            w_rsp_data_nxt = '0;
        end else if (w_sample) begin
            w_rsp_data_nxt = bus.mem_rdata;
        end else begin
            w_rsp_data_nxt = r_rsp_data;
        end

        // mismatch flag only meaningful for verify; dropped on handshake
        if (w_accept) begin
            w_rsp_err_nxt = 1'b0;
        end else if (w_sample) begin
            w_rsp_err_nxt = (r_op == OP_VERIFY) && (bus.mem_rdata != r_data);
        end else if ((r_state == ST_RESP) && bus.rsp_ready) begin
            w_rsp_err_nxt = 1'b0;
        end else begin
            w_rsp_err_nxt = r_rsp_err;
        end
    end

    // output and datapath registers
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_op        <= 2'b00;
            r_data      <= '0;
            r_wait_cnt  <= 4'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_clear <= 1'b0;
        end else begin
            r_op        <= w_op_nxt;
            r_data      <= w_data_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_rw    <= w_mem_rw_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_clear <= w_mem_clear_nxt;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_clear = r_mem_clear;

endmodule
